// File: rtl/decode_pkg.sv
// decode_pkg -- shared definitions for the decode stage.
//   state_e            : decode FSM states (IDLE, ISSUE, SLEEP)
//   UC_*               : bit positions inside the microcommand word
//   OPC_HALT / OPC_WAIT: full 16-bit encodings of the sleep instructions
//   INST_TYPE_*        : instruction-type codes found in IR[15:13]
package decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_SLEEP = 2'd2
    } state_e;

    localparam int UC_IMM_EXTEND_NEGATIVE = 5;
    localparam int UC_IMM_SHIFT           = 6;
    localparam int UC_LAST_PHASE          = 7;

    localparam logic [15:0] OPC_HALT = 16'hE000;
    localparam logic [15:0] OPC_WAIT = 16'hE200;

    localparam logic [2:0] INST_TYPE_IMM6 = 3'd3;
    localparam logic [2:0] INST_TYPE_IMM9 = 3'd4;

    // True for the two instructions that park the stage in SLEEP.
    function automatic logic is_sleep_opc(input logic [15:0] ir);
        return (ir == OPC_HALT) || (ir == OPC_WAIT);
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen -- combinational immediate extraction, shift and extension.
// Ports:
//   field_i      : IR[8:0]; imm6 lives in [8:3], imm9 in [8:0]
//   sel_imm6_i   : 1 selects the 6-bit field, 0 the 9-bit field
//   is_int_i     : INT encoding: (imm << 2) | (phase[0] ? 2 : 0)
//   phase_lsb_i  : phase[0] of the current phase
//   extend_neg_i : fill value for every bit above the field
//   shift_i      : shift the field left by one (non-INT only)
//   imm_o        : DATA_W-bit immediate
module imm_gen
    import decode_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [8:0]        field_i,
    input  logic              sel_imm6_i,
    input  logic              is_int_i,
    input  logic              phase_lsb_i,
    input  logic              extend_neg_i,
    input  logic              shift_i,
    output logic [DATA_W-1:0] imm_o
);

    logic [5:0] sh6;
    logic [8:0] sh9;

    // The shift acts inside the field width; the extension fill then owns
    // every bit above the field. This is what makes imm6=1, shift=1,
    // fill=1 come out as 0xFFC2 rather than 0xFF82.
    always_comb begin
        sh6 = shift_i ? {field_i[7:3], 1'b0} : field_i[8:3];
        if (is_int_i) begin
            sh9 = {field_i[6:0], 2'b00} | {7'd0, phase_lsb_i, 1'b0};
        end else if (shift_i) begin
            sh9 = {field_i[7:0], 1'b0};
        end else begin
            sh9 = field_i;
        end

        if (sel_imm6_i) begin
            imm_o = {{(DATA_W-6){extend_neg_i}}, sh6};
        end else begin
            imm_o = {{(DATA_W-9){extend_neg_i}}, sh9};
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- holds one instruction in IR and walks it through its
// microcode phases, presenting one decoded phase per out handshake.
//
// Optional feature macro: DECODE_STAGE_SKID_EN adds a one-entry prefetch
// buffer so a following instruction can be accepted during ISSUE and
// issued with zero bubble after the last phase.
//
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : instruction fetch handshake
//   instruction          : 16-bit instruction word
//   ucommand             : microcommand for the current phase
//   out_valid / out_ready: decoded-phase handshake to execute
//   wake                 : leave SLEEP
//   phase, ucode_addr    : phase index and {type, IR[12:9], phase}
//   imm                  : extended / shifted immediate
//   rs1, rs2, rd         : register fields of IR
//   is_int/is_halt/is_wait: instruction class flags
//   stalled              : high in SLEEP
//   dbg_state            : current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; a valid source holds its data until that edge, and ready
// may be asserted without valid. in_ready and out_valid are registered.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PHASE_W  = 3,
    parameter int UCMD_W   = 28,
    parameter int UCODE_AW = 7 + PHASE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         instruction,
    input  logic [UCMD_W-1:0]   ucommand,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                wake,
    output logic [PHASE_W-1:0]  phase,
    output logic [UCODE_AW-1:0] ucode_addr,
    output logic [DATA_W-1:0]   imm,
    output logic [2:0]          rs1,
    output logic [2:0]          rs2,
    output logic [2:0]          rd,
    output logic                is_int,
    output logic                is_halt,
    output logic                is_wait,
    output logic                stalled,
    output state_e              dbg_state
);

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [15:0]        ir_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               stalled_q;
`ifdef DECODE_STAGE_SKID_EN
    logic [15:0]        skid_q;
    logic               skid_valid_q;
`endif

    logic       accept;
    logic       last_phase;
    logic [2:0] inst_type;
    logic       unused_ucmd;

    assign accept     = in_valid && in_ready_q;
    assign last_phase = ucommand[UC_LAST_PHASE];
    assign inst_type  = ir_q[15:13];

    // Only the extend, shift and last-phase bits matter to this stage.
    assign unused_ucmd = ^{ucommand[UCMD_W-1:8], ucommand[4:0]};

    assign is_int  = (inst_type == INST_TYPE_IMM9) && (ir_q[12:10] == 3'd0);
    assign is_halt = (ir_q == OPC_HALT);
    assign is_wait = (ir_q == OPC_WAIT);
    assign rs1     = ir_q[2:0];
    assign rs2     = ir_q[5:3];
    assign rd      = ir_q[8:6];

    assign phase      = phase_q;
    assign ucode_addr = {ir_q[15:9], phase_q};
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign stalled    = stalled_q;
    assign dbg_state  = state_q;

    imm_gen #(
        .DATA_W (DATA_W)
    ) u_imm_gen (
        .field_i      (ir_q[8:0]),
        .sel_imm6_i   (inst_type == INST_TYPE_IMM6),
        .is_int_i     (is_int),
        .phase_lsb_i  (phase_q[0]),
        .extend_neg_i (ucommand[UC_IMM_EXTEND_NEGATIVE]),
        .shift_i      (ucommand[UC_IMM_SHIFT]),
        .imm_o        (imm)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            ir_q         <= '0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b0;
            stalled_q    <= 1'b0;
`ifdef DECODE_STAGE_SKID_EN
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // in_ready rises on the first edge after reset release.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        ir_q        <= instruction;
                        phase_q     <= '0;
                        state_q     <= ST_ISSUE;
                        out_valid_q <= 1'b1;
`ifdef DECODE_STAGE_SKID_EN
                        in_ready_q  <= 1'b1;
`else
                        in_ready_q  <= 1'b0;
`endif
                    end
                end

                ST_ISSUE: begin
`ifdef DECODE_STAGE_SKID_EN
                    // Prefetch while the current instruction is still issuing.
                    if (accept) begin
                        skid_q       <= instruction;
                        skid_valid_q <= 1'b1;
                        in_ready_q   <= 1'b0;
                    end
`endif
                    if (out_ready) begin
                        if (!last_phase) begin
                            // Natural modulo wrap at the counter maximum.
                            phase_q <= phase_q + 1'b1;
                        end else if (is_sleep_opc(ir_q)) begin
                            state_q     <= ST_SLEEP;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b0;
                            stalled_q   <= 1'b1;
                        end else begin
`ifdef DECODE_STAGE_SKID_EN
                            if (skid_valid_q) begin
                                ir_q         <= skid_q;
                                skid_valid_q <= 1'b0;
                                phase_q      <= '0;
                                in_ready_q   <= 1'b1;
                            end else if (accept) begin
                                // Buffer empty: bypass straight into IR.
                                ir_q         <= instruction;
                                skid_valid_q <= 1'b0;
                                phase_q      <= '0;
                                in_ready_q   <= 1'b1;
                            end else begin
                                state_q      <= ST_IDLE;
                                out_valid_q  <= 1'b0;
                                in_ready_q   <= 1'b1;
                            end
`else
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
`endif
                        end
                    end
                end

                ST_SLEEP: begin
                    // in_ready is low here, so an in_valid coinciding with
                    // wake is never accepted in this cycle.
                    if (wake) begin
                        stalled_q  <= 1'b0;
                        in_ready_q <= 1'b1;
`ifdef DECODE_STAGE_SKID_EN
                        if (skid_valid_q) begin
                            ir_q         <= skid_q;
                            skid_valid_q <= 1'b0;
                            phase_q      <= '0;
                            state_q      <= ST_ISSUE;
                            out_valid_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
`else
                        state_q <= ST_IDLE;
`endif
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    stalled_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage -- randomized scoreboard bench for decode_stage.
// Each phase handshake pushes the expected decoded outputs computed by a
// plain-arithmetic reference model; a monitor pops and compares on every
// out_valid && out_ready cycle. Directed blocks cover reset, stalls,
// sleep/wake, phase wrap and the worked immediate examples.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int DW = 16;
    localparam int PW = 3;
    localparam int UW = 28;
    localparam int AW = 7 + PW;
    localparam int EW = DW + PW + AW + 9 + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          wake = 1'b0;
    logic [15:0]   instruction = '0;
    logic [UW-1:0] ucommand = '0;
    logic          in_ready, out_valid, is_int, is_halt, is_wait, stalled;
    logic [PW-1:0] phase;
    logic [AW-1:0] ucode_addr;
    logic [DW-1:0] imm;
    logic [2:0]    rs1, rs2, rd;
    state_e        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    decode_stage #(.DATA_W(DW), .PHASE_W(PW), .UCMD_W(UW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .ucommand(ucommand), .out_valid(out_valid),
        .out_ready(out_ready), .wake(wake), .phase(phase), .ucode_addr(ucode_addr),
        .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .is_int(is_int),
        .is_halt(is_halt), .is_wait(is_wait), .stalled(stalled), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decoded outputs for phase number k (counting from 0).
    function automatic logic [EW-1:0] model(input logic [15:0] ins, input int k,
                                            input bit ext, input bit shf);
        int ty, sub, width, raw, val, ph, uc;
        bit isint;
        logic [2:0] f_rd, f_rs2, f_rs1;
        ty  = int'(ins >> 13);
        sub = int'((ins >> 10) & 16'd7);
        ph  = k % 8;
        if (ty == 3) begin
            width = 6;
            raw   = int'((ins >> 3) & 16'd63);
        end else begin
            width = 9;
            raw   = int'(ins & 16'd511);
        end
        isint = (ty == 4) && (sub == 0);
        if (isint) val = raw * 4 + (ph % 2) * 2;
        else       val = raw * (shf ? 2 : 1);
        val = val % (1 << width);
        if (ext) val = val + (65536 - (1 << width));
        uc    = int'(ins >> 9) * 8 + ph;
        f_rs1 = 3'(ins % 8);
        f_rs2 = 3'((ins / 8) % 8);
        f_rd  = 3'((ins / 64) % 8);
        return {val[15:0], ph[2:0], uc[9:0], f_rd, f_rs2, f_rs1, isint,
                ins == 16'hE000, ins == 16'hE200};
    endfunction

    // ---------------- drivers ----------------
    task automatic fetch(input logic [15:0] ins);
        int g;
        g = 0;
        instruction = ins;
        in_valid    = 1'b1;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) begin
            errors++;
            checks++;
            $display("FAIL fetch_timeout: in_ready stuck low for %0h", ins);
        end
        tick();
        in_valid    = 1'b0;
        instruction = 16'($urandom());
    endtask

    task automatic phase_hs(input logic [15:0] ins, input int k, input bit last,
                            input bit ext, input bit shf, input bit rnd);
        int g;
        g = 0;
        ucommand = UW'($urandom());
        ucommand[UC_IMM_EXTEND_NEGATIVE] = ext;
        ucommand[UC_IMM_SHIFT]           = shf;
        ucommand[UC_LAST_PHASE]          = last;
        exp_q.push_back(model(ins, k, ext, shf));
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(out_valid && out_ready) && g < 100) begin
            tick();
            g++;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        if (g >= 100) begin
            errors++;
            checks++;
            $display("FAIL phase_timeout: no handshake, ins %0h phase %0d", ins, k);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic send(input logic [15:0] ins, input int nph, input bit rnd);
        fetch(ins);
        for (int k = 0; k < nph; k++)
            phase_hs(ins, k, k == nph - 1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), rnd);
        if (ins == OPC_HALT || ins == OPC_WAIT) begin
            check("sleep_stalled", stalled, 1);
            check("sleep_in_ready", in_ready, 0);
            check("sleep_out_valid", out_valid, 0);
            repeat ($urandom_range(1, 3)) tick();
            // in_valid coinciding with wake must not be taken.
            wake        = 1'b1;
            in_valid    = 1'b1;
            instruction = 16'h1357;
            tick();
            wake     = 1'b0;
            in_valid = 1'b0;
            check("wake_stalled", stalled, 0);
            check("wake_state", dbg_state, ST_IDLE);
            check("wake_in_ready", in_ready, 1);
            check("wake_no_accept", out_valid, 0);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL scoreboard_unexpected: phase %0d imm %0h", phase, imm);
                end else begin
                    check("scoreboard", {imm, phase, ucode_addr, rd, rs2, rs1,
                                         is_int, is_halt, is_wait}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ins;
        logic [7:0]  s_phase;
        logic [15:0] s_imm;
        int nph;
`ifdef DECODE_STAGE_SKID_EN
        logic [15:0] seq[4];
        int acc, issued, cyc, first_c, last_c;
        bit hs_in, hs_out;
`endif

        // Reset values while rst_n is low.
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_phase", phase, 0);
        check("rst_ucode_addr", ucode_addr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("in_ready_after_release", in_ready, 1);
        check("idle_state", dbg_state, ST_IDLE);

        // imm6 example plus four stalled cycles in ISSUE.
        fetch(16'h6008);
        ucommand = '0;
        ucommand[UC_IMM_EXTEND_NEGATIVE] = 1'b1;
        ucommand[UC_IMM_SHIFT]           = 1'b1;
        ucommand[UC_LAST_PHASE]          = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_imm6", imm, 16'hFFC2);
            check("stall_phase", phase, 0);
`ifndef DECODE_STAGE_SKID_EN
            check("stall_in_ready", in_ready, 0);
`endif
            tick();
        end
        phase_hs(16'h6008, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        // INT example across two phases.
        fetch(16'h8005);
        ucommand = '0;
        #1;
        check("int_imm_p0", imm, 16'h0014);
        phase_hs(16'h8005, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        ucommand = '0;
        #1;
        check("int_phase_p1", phase, 1);
        check("int_imm_p1", imm, 16'h0016);
        phase_hs(16'h8005, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Phase counter wrap (10 phases on a 3-bit counter), then sleeps.
        send(16'h2A5C, 10, 1'b1);
        send(16'h9C07, 9, 1'b0);
        send(OPC_HALT, 1, 1'b0);
        send(OPC_WAIT, 2, 1'b1);

        // Reset asserted during phase 2 of a 3-phase instruction.
        fetch(16'h1234);
        phase_hs(16'h1234, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        phase_hs(16'h1234, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        ucommand  = '0;
        out_ready = 1'b0;
        #3;
        s_phase = 8'(phase);
        check("pre_reset_phase", s_phase, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_phase", phase, 0);
        check("midrst_ucode_addr", ucode_addr, 0);
        check("midrst_rd", rd, 0);
        check("midrst_stalled", stalled, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_state", dbg_state, ST_IDLE);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rerelease_in_ready", in_ready, 1);
        send(16'h4C21, 3, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom());
            case ($urandom_range(0, 9))
                0: ins = OPC_HALT;
                1: ins = OPC_WAIT;
                2: ins = {3'd4, 3'd0, ins[9:0]};
                3: ins = {3'd3, ins[12:0]};
                default: ;
            endcase
            nph = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(1, 4);
            send(ins, nph, 1'b1);
        end
        s_imm = 16'(exp_q.size());

`ifdef DECODE_STAGE_SKID_EN
        // Back-to-back single-phase instructions through the prefetch buffer.
        seq = '{16'h0111, 16'h2222, 16'h4C33, 16'h6044};
        ucommand = '0;
        ucommand[UC_LAST_PHASE] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(model(seq[i], 0, 1'b0, 1'b0));
        acc = 0; issued = 0; cyc = 0; first_c = 0; last_c = 0;
        in_valid = 1'b1;
        instruction = seq[0];
        while (issued < 4 && cyc < 60) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            tick();
            if (hs_in) begin
                acc++;
                if (acc < 4) instruction = seq[acc];
                else in_valid = 1'b0;
            end
            if (hs_out) begin
                if (issued == 0) first_c = cyc;
                issued++;
                if (issued == 4) last_c = cyc;
            end
            cyc++;
        end
        out_ready = 1'b0;
        check("skid_issued", issued, 4);
        check("skid_back_to_back", last_c - first_c, 3);
`endif

        repeat (3) tick();
        check("queue_drained_mid", s_imm, 0);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
